// File: rtl/shift_chain_ctrl.sv
// Serializes a latched pattern into an external enable-gated register chain and recovers it from
// the chain tail. Optional compare of recovered vs sent bits under SHIFT_CHAIN_CTRL_CHECK_EN.
module shift_chain_ctrl #(
    parameter int unsigned DEPTH  = 5,
    parameter int unsigned MAXLEN = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [MAXLEN-1:0] data_in,
    input  logic [3:0]        len,
    input  logic              stall,
    input  logic              chain_dout,
    output logic              chain_en,
    output logic              chain_din,
    output logic              busy,
    output logic              done,
    output logic [MAXLEN-1:0] captured,
    output logic              mismatch
);

    localparam int unsigned IdxW = $clog2(MAXLEN);
    localparam logic [4:0] DepthW = 5'(DEPTH);
    localparam logic [IdxW-1:0] DepthLo = IdxW'(DEPTH);
    localparam logic [3:0] MaxLen4 = 4'(MAXLEN);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLast,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        sc_q, sc_d;
    logic [3:0]        len_q, len_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [MAXLEN-1:0] captured_q, captured_d;

    logic [4:0]        last_sc;
    logic [3:0]        len_clamped;
    logic              capture_win;
    logic [IdxW-1:0]   cap_idx;

    always_comb begin
        len_clamped = (len > MaxLen4) ? MaxLen4 : len;
        last_sc     = {1'b0, len_q} + DepthW - 5'd1;
        capture_win = ({1'b0, sc_q} >= DepthW) && ({1'b0, sc_q} <= last_sc);
        // Window guarantees sc - DEPTH lies in 0..L-1, so modular low bits are exact.
        cap_idx     = sc_q[IdxW-1:0] - DepthLo;
    end

    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        len_d      = len_q;
        pattern_d  = pattern_q;
        captured_d = captured_q;
        chain_en   = 1'b0;
        chain_din  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && (len != 4'd0)) begin
                    pattern_d  = data_in;
                    len_d      = len_clamped;
                    sc_d       = 4'd0;
                    captured_d = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (!stall) begin
                    chain_en = 1'b1;
                    if (sc_q < len_q) begin
                        chain_din = pattern_q[sc_q[IdxW-1:0]];
                    end
                    sc_d = sc_q + 4'd1;
                    if (capture_win) begin
                        captured_d[cap_idx] = chain_dout;
                    end
                    if (({1'b0, sc_q} + 5'd1) == last_sc) begin
                        state_d = StLast;
                    end
                end
            end
            StLast: begin
                // Last bit reached the tail on the final enabled edge; take it without shifting.
                if (capture_win) begin
                    captured_d[cap_idx] = chain_dout;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            sc_q       <= 4'd0;
            len_q      <= 4'd0;
            pattern_q  <= '0;
            captured_q <= '0;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            len_q      <= len_d;
            pattern_q  <= pattern_d;
            captured_q <= captured_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign captured = captured_q;

`ifdef SHIFT_CHAIN_CTRL_CHECK_EN
    localparam logic [MAXLEN:0] One = 1;
    logic [MAXLEN:0] len_mask;

    always_comb begin
        len_mask = (One << len_q) - One;
        mismatch = (state_q == StDone) &&
                   (((captured_q ^ pattern_q) & len_mask[MAXLEN-1:0]) != '0);
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed bench for shift_chain_ctrl with a 5-stage enable-gated chain attached.
module tb_shift_chain_ctrl;

    localparam int DEPTH = 5;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] len;
    logic       stall;
    logic       chain_dout;
    logic       chain_en;
    logic       chain_din;
    logic       busy;
    logic       done;
    logic [7:0] captured;
    logic       mismatch;

    logic [DEPTH-1:0] chain_q;
    logic             force_zero;

    int checks = 0;
    int passes = 0;

    shift_chain_ctrl #(
        .DEPTH (DEPTH),
        .MAXLEN(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .data_in   (data_in),
        .len       (len),
        .stall     (stall),
        .chain_dout(chain_dout),
        .chain_en  (chain_en),
        .chain_din (chain_din),
        .busy      (busy),
        .done      (done),
        .captured  (captured),
        .mismatch  (mismatch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (chain_en) chain_q <= {chain_q[DEPTH-2:0], chain_din};
    end
    assign chain_dout = force_zero ? 1'b0 : chain_q[DEPTH-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start at edge 0, then observe cycles 1.. at negedge. rs_mask re-pulses start per cycle.
    task automatic run_op(input logic [7:0] d, input logic [3:0] l, input logic [31:0] stall_mask,
                          input logic [31:0] rs_mask, output int en_cnt, output int done_cyc,
                          output logic [31:0] en_map, output logic mm_done, output logic busy_c1);
        @(negedge CLK);
        start = 1'b1; data_in = d; len = l; stall = 1'b0;
        @(posedge CLK);
        en_cnt = 0; done_cyc = -1; en_map = '0; mm_done = 1'b0; busy_c1 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            #1;
            start   = rs_mask[n];
            data_in = rs_mask[n] ? 8'hFF : 8'h00;
            len     = rs_mask[n] ? 4'd8 : 4'd0;
            stall   = stall_mask[n];
            @(negedge CLK);
            if (n == 1) busy_c1 = busy;
            if (chain_en) begin
                en_cnt++;
                en_map[n] = 1'b1;
            end
            if (done && done_cyc < 0) begin
                done_cyc = n;
                mm_done  = mismatch;
            end
            @(posedge CLK);
            if (done_cyc >= 0) break;
        end
        #1;
        start = 1'b0; stall = 1'b0;
    endtask

    int          en_cnt;
    int          done_cyc;
    logic [31:0] en_map;
    logic        mm_done;
    logic        busy_c1;
    logic        exp_mm;

    initial begin
        RST = 1'b1; start = 1'b0; data_in = '0; len = '0; stall = 1'b0; force_zero = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_chain_en", 32'(chain_en), 0);
        check("rst_chain_din", 32'(chain_din), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_captured", 32'(captured), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        RST = 1'b0;

        // A5, len 8: en cycles 1..12, done cycle 14
        run_op(8'hA5, 4'd8, 0, 0, en_cnt, done_cyc, en_map, mm_done, busy_c1);
        check("a5_en_cnt", 32'(en_cnt), 12);
        check("a5_en_map", en_map, 32'h0000_1FFE);
        check("a5_done_cyc", 32'(done_cyc), 14);
        check("a5_captured", 32'(captured), 32'hA5);
        check("a5_mismatch", 32'(mm_done), 0);
        check("a5_busy_c1", 32'(busy_c1), 1);
        @(negedge CLK);
        check("a5_done_single", 32'(done), 0);
        check("a5_busy_after", 32'(busy), 0);

        // FD, len 3: done cycle 9, low three bits recovered
        run_op(8'hFD, 4'd3, 0, 0, en_cnt, done_cyc, en_map, mm_done, busy_c1);
        check("fd_en_cnt", 32'(en_cnt), 7);
        check("fd_done_cyc", 32'(done_cyc), 9);
        check("fd_captured", 32'(captured), 32'h05);

        // Stall in cycles 4 and 5 pushes done to cycle 16
        run_op(8'hC3, 4'd8, 32'h30, 0, en_cnt, done_cyc, en_map, mm_done, busy_c1);
        check("stall_en_map", en_map, 32'h0000_7FCE);
        check("stall_done_cyc", 32'(done_cyc), 16);
        check("stall_captured", 32'(captured), 32'hC3);

        // len above 8 clamps to 8
        run_op(8'h69, 4'd12, 0, 0, en_cnt, done_cyc, en_map, mm_done, busy_c1);
        check("clamp_done_cyc", 32'(done_cyc), 14);
        check("clamp_captured", 32'(captured), 32'h69);

        // len 0 start is ignored
        @(negedge CLK);
        start = 1'b1; data_in = 8'hFF; len = 4'd0;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        check("len0_busy", 32'(busy), 0);
        check("len0_done", 32'(done), 0);
        check("len0_captured", 32'(captured), 32'h69);

        // start while busy (cycle 3) and during DONE (cycle 10) is ignored
        run_op(8'h5A, 4'd4, 0, 32'h408, en_cnt, done_cyc, en_map, mm_done, busy_c1);
        check("busy_start_en_cnt", 32'(en_cnt), 8);
        check("busy_start_done_cyc", 32'(done_cyc), 10);
        check("busy_start_captured", 32'(captured), 32'h0A);
        @(negedge CLK);
        check("busy_start_idle", 32'(busy), 0);

        // Reset asserted in cycle 6 aborts the run
        @(negedge CLK);
        start = 1'b1; data_in = 8'hA5; len = 4'd8;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        check("abort_pre_en", 32'(chain_en), 1);
        RST = 1'b1;
        #1;
        check("abort_chain_en", 32'(chain_en), 0);
        check("abort_chain_din", 32'(chain_din), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_captured", 32'(captured), 0);
        @(posedge CLK);
        #1;
        check("abort_no_done", 32'(done), 0);
        RST = 1'b0;

        // First edge after reset release accepts a start
        run_op(8'h96, 4'd8, 0, 0, en_cnt, done_cyc, en_map, mm_done, busy_c1);
        check("post_rst_done_cyc", 32'(done_cyc), 14);
        check("post_rst_captured", 32'(captured), 32'h96);

        // Tail forced low: nothing recovered, compare flags it when enabled
        force_zero = 1'b1;
        run_op(8'hFF, 4'd8, 0, 0, en_cnt, done_cyc, en_map, mm_done, busy_c1);
        force_zero = 1'b0;
`ifdef SHIFT_CHAIN_CTRL_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        check("zero_captured", 32'(captured), 0);
        check("zero_done_cyc", 32'(done_cyc), 14);
        check("zero_mismatch", 32'(mm_done), 32'(exp_mm));
        @(negedge CLK);
        check("zero_mismatch_after", 32'(mismatch), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shift_chain_ctrl.md
SHIFT_CHAIN_CTRL -- requirements
Module: shift_chain_ctrl

Interface
REQ-001 Parameter DEPTH, default 5: number of enable-gated register stages in the controlled chain (range 1..8).
REQ-002 Parameter MAXLEN, default 8: maximum pattern length in bits (fixed at 8; sets data_in/captured width).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  command strobe; sampled on a rising CLK edge.
REQ-006 data_in  input  8  pattern to serialize, LSB first; latched on accepted start.
REQ-007 len  input  4  pattern length in bits; latched on accepted start.
REQ-008 stall  input  1  when high, freezes sequencing for that cycle.
REQ-009 chain_dout  input  1  output of the last chain stage.
REQ-010 chain_en  output  1  enable driven to every chain stage.
REQ-011 chain_din  output  1  serial data into the first chain stage.
REQ-012 busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 captured  output  8  bits recovered from chain_dout; bit k = k-th bit shifted in.
REQ-015 mismatch  output  1  compare result (see Configuration).

Function
REQ-016 States: IDLE, SHIFT, LAST, DONE; encoding is free.
REQ-017 start is accepted only in IDLE with len != 0; otherwise ignored (no state, latch or output change).
REQ-018 On acceptance: latch data_in, latch L = min(len, 8), clear shift counter sc and captured, go to SHIFT.
REQ-019 SHIFT, stall low: chain_en=1; chain_din = pattern[sc] when sc < L, else 0; sc increments at the edge.
REQ-020 SHIFT, stall high: chain_en=0, chain_din=0, sc and captured hold.
REQ-021 Capture: in any SHIFT cycle with stall low and in LAST, when DEPTH <= sc <= L+DEPTH-1, captured[sc-DEPTH] <= chain_dout at that edge.
REQ-022 SHIFT -> LAST at the edge where sc goes to L+DEPTH-1 (exactly L+DEPTH-1 enabled edges total).
REQ-023 LAST (stall ignored): chain_en=0, final capture performed, -> DONE.
REQ-024 DONE: done=1 for exactly one cycle, busy=1, -> IDLE; captured holds until the next accepted start.
REQ-025 Timing with no stall: start sampled at edge 0; chain_en high cycles 1..L+DEPTH-1; done high in cycle L+DEPTH+1.
REQ-026 Each stalled cycle in SHIFT delays done by exactly one cycle.
REQ-027 chain_en=0 and chain_din=0 in IDLE, LAST and DONE.
REQ-028 sc width is 4 bits; no wrap occurs for DEPTH<=8 and L<=8.

Reset
REQ-029 RST high forces IDLE, sc=0, pattern=0, L=0, captured=0, chain_en=0, chain_din=0, busy=0, done=0, mismatch=0, asynchronously.
REQ-030 RST mid-operation aborts the sequence; no done pulse; chain contents are not cleared by this block.
REQ-031 First accepted start is possible at the first edge after RST deasserts.

Configuration
REQ-032 Macro SHIFT_CHAIN_CTRL_CHECK_EN.
REQ-033 Defined: in DONE, mismatch=1 for that one cycle if captured[L-1:0] != pattern[L-1:0]; else mismatch=0.
REQ-034 Undefined: mismatch tied to 0 and no compare logic is present; all other behaviour is identical.

Verification (DEPTH=5, chain of 5 enable-gated registers attached)
REQ-035 start, data_in=0xA5, len=8 -> chain_en high for exactly 12 cycles, done in cycle 14, captured=0xA5, mismatch=0.
REQ-036 start, data_in=0xFD, len=3 -> done in cycle 9, captured=0x05.
REQ-037 len=8, stall high in cycles 4 and 5 -> done in cycle 16, captured equal to data_in, chain_en low in cycles 4-5.
REQ-038 start with len=0, then start while busy -> both ignored; busy and done unaffected; the in-progress run completes unchanged.
REQ-039 RST asserted in cycle 6 of a run -> all outputs 0 immediately, no done; a following start completes normally.
REQ-040 With SHIFT_CHAIN_CTRL_CHECK_EN defined, chain_dout forced 0, data_in=0xFF, len=8 -> captured=0x00, mismatch pulses with done.
